axi_rd_byte_streamer: RTL and testbench
=======================================

// Module: axi_rd_byte_streamer
// PURPOSE
//  Sequencer downstream of axi_rd on the FPGA-to-HPS read path. It reads a block of NUM words from AXI memory.
//  It splits the block into bursts of up to MAX_BURST_LEN beats and drives axi_rd's enable/status handshake for each burst.
//  It unpacks each returned burst into a little-endian byte stream with valid/ready, for the UART TX path.
// PARAMETERS
//  ADDR_WIDTH     32  AXI address width
//  BUS_WIDTH      32  AXI data width in bits; must be 8,16,32,64 or 128
//  MAX_BURST_LEN  4   max beats per burst, 1..16; must match the axi_rd instance
//  RD_ID          0   constant AXI read ID (8 bits)
// PORTS
//  clock         in   1                      system clock; all logic on rising edge
//  reset         in   1                      synchronous, active-high reset
//  start         in   1                      1-cycle pulse; begins a block read when idle
//  base_addr     in   ADDR_WIDTH             first byte address; low log2(BUS_WIDTH/8) bits forced to 0
//  num_words     in   16                     bus words to read; 0 means empty job
//  busy          out  1                      high from accepted start until done
//  done          out  1                      1-cycle pulse at job end
//  error         out  1                      valid with done; 1 = an AXI read returned status 3
//  rd_enable     out  1                      to axi_rd enable
//  rd_id         out  8                      to axi_rd id = RD_ID
//  rd_addr       out  ADDR_WIDTH             to axi_rd addr
//  rd_burst_len  out  4                      to axi_rd burst_len = beats-1
//  rd_burst_size out  3                      to axi_rd burst_size = log2(BUS_WIDTH/8), constant
//  rd_data       in   MAX_BURST_LEN*BUS_WIDTH from axi_rd data; beat k at bits [k*BUS_WIDTH +: BUS_WIDTH]
//  rd_status     in   2                      from axi_rd status: 0 ready, 1 wait, 2 ok, 3 error
//  out_data      out  8                      stream byte
//  out_valid     out  1                      stream valid
//  out_ready     in   1                      stream ready from the UART TX FIFO
// BEHAVIOUR
//  Reset values: busy=0, done=0, error=0, rd_enable=0, out_valid=0, out_data=0, rd_addr=0, rd_burst_len=0; FSM goes to IDLE.
//  Reset mid-job abandons the job. rd_enable drops on the next cycle; axi_rd may finish its transaction unobserved.
//  FSM states: IDLE, REQ, WAIT, DRAIN, FINISH.
//  IDLE:
//   - start=1 latches the aligned base_addr and num_words into addr/remaining, clears error, sets busy=1.
//   - Goes to FINISH if num_words==0, else to REQ.
//   - start is ignored when not in IDLE.
//  REQ:
//   - Waits for rd_status==0.
//   - Computes beats = min(remaining, MAX_BURST_LEN, words left before the next 4 KB boundary). Bursts never cross 4 KB.
//   - Drives rd_addr=addr and rd_burst_len=beats-1 and asserts rd_enable. Goes to WAIT.
//   - rd_addr and rd_burst_len stay stable while rd_enable=1.
//  WAIT:
//   - Holds rd_enable=1 until rd_status>=2.
//   - On that cycle: rd_enable<=0, captures rd_data into the local buffer, addr += beats*BUS_WIDTH/8 (wraps mod 2^ADDR_WIDTH), remaining -= beats.
//   - rd_status==2: goes to DRAIN.
//   - rd_status==3: sets error=1, discards the captured bytes, goes to FINISH (remaining words abandoned).
//  DRAIN:
//   - Emits beats*BUS_WIDTH/8 bytes from the buffer: beat 0 first, byte 0 (bits [7:0]) of each beat first.
//   - out_valid=1 throughout. A byte transfers on out_valid&&out_ready.
//   - out_data must not change while out_valid&&!out_ready. No bubbles when out_ready stays high (1 byte/cycle).
//   - After the last byte transfers: goes to REQ if remaining>0, else FINISH.
//   - No AXI request overlaps DRAIN.
//  FINISH:
//   - done=1 for exactly one cycle, busy<=0, error held until the next accepted start. Goes to IDLE.
//  Latency: start to first rd_enable is 2 cycles when rd_status==0. WAIT to first out_valid is 1 cycle.
//  Counters: remaining is 16 bits. The byte index counts 0..MAX_BURST_LEN*BUS_WIDTH/8-1.
// TESTING
//  1. base=0x1000, num=4, MAX=4, BUS=32, model returns 0x03020100,0x07060504,..., out_ready=1 -> one burst len=3; bytes 0x00..0x0F in order; done, error=0.
//  2. num=10, MAX=4 -> bursts at 0x1000/0x1010/0x1020 with len 3,3,1; 40 bytes total; done after the last byte.
//  3. base=0x1FF8, num=4 -> bursts len=1 @0x1FF8 then len=1 @0x2000 (4 KB split); 16 bytes in order.
//  4. 2nd burst returns status 3 -> bytes of burst 1 only, no 3rd request, done with error=1.
//  5. out_ready toggled randomly -> out_data stable while stalled; no byte lost or duplicated vs. the model.
//  6. num=0 -> no rd_enable, done 2 cycles after start; reset asserted in WAIT -> rd_enable=0 and out_valid=0 next cycle, back to IDLE.

Source files
------------

// File: rtl/axi_rd_byte_streamer.sv
// Block-read sequencer in front of axi_rd: splits a word block into 4 KB-safe bursts
// and unpacks each returned burst into a little-endian byte stream with valid/ready.
module axi_rd_byte_streamer #(
  parameter int          ADDR_WIDTH    = 32,
  parameter int          BUS_WIDTH     = 32,
  parameter int          MAX_BURST_LEN = 4,
  parameter logic [7:0]  RD_ID         = 8'd0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [15:0]                          num_words,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic                                 rd_enable,
  output logic [7:0]                           rd_id,
  output logic [ADDR_WIDTH-1:0]                rd_addr,
  output logic [3:0]                           rd_burst_len,
  output logic [2:0]                           rd_burst_size,
  input  logic [MAX_BURST_LEN*BUS_WIDTH-1:0]   rd_data,
  input  logic [1:0]                           rd_status,
  output logic [7:0]                           out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready
);

  localparam int BPB       = BUS_WIDTH / 8;
  localparam int SIZE      = $clog2(BPB);
  localparam int BUF_BYTES = MAX_BURST_LEN * BPB;
  localparam int IDX_W     = $clog2(BUF_BYTES + 1);
  localparam int BUF_W     = MAX_BURST_LEN * BUS_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BPB - 1));

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  logic [2:0]            state_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [15:0]           remaining_r;
  logic [4:0]            beats_r;
  logic [IDX_W-1:0]      last_idx_r;
  logic [IDX_W-1:0]      byte_idx_r;
  logic [BUF_W-1:0]      buf_r;

  logic [12:0]           page_words_s;
  logic [4:0]            cap_s;
  logic [4:0]            beats_s;
  logic [IDX_W-1:0]      last_idx_s;
  logic [IDX_W-1:0]      next_idx_s;
  logic [BUF_W-1:0]      buf_shift_s;

  assign rd_id         = RD_ID;
  assign rd_burst_size = 3'(SIZE);

  // Burst sizing: limited by words left, MAX_BURST_LEN and the distance to the next 4 KB page.
  always_comb begin
    page_words_s = (13'h1000 - {1'b0, addr_r[11:0]}) >> SIZE;
    cap_s        = (remaining_r > 16'(MAX_BURST_LEN)) ? 5'(MAX_BURST_LEN) : remaining_r[4:0];
    beats_s      = ({8'd0, cap_s} > page_words_s) ? page_words_s[4:0] : cap_s;
    last_idx_s   = IDX_W'(({27'd0, beats_s} << SIZE) - 32'd1);
    next_idx_s   = byte_idx_r + IDX_W'(1);
    buf_shift_s  = buf_r >> {next_idx_s, 3'b000};
  end

  // Job sequencer, axi_rd handshake and byte-stream output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      remaining_r  <= 16'd0;
      beats_r      <= 5'd0;
      last_idx_r   <= '0;
      byte_idx_r   <= '0;
      buf_r        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      rd_enable    <= 1'b0;
      rd_addr      <= '0;
      rd_burst_len <= 4'd0;
      out_data     <= 8'd0;
      out_valid    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            addr_r      <= base_addr & ALIGN_MASK;
            remaining_r <= num_words;
            error       <= 1'b0;
            busy        <= 1'b1;
            state_r     <= (num_words == 16'd0) ? ST_FINISH : ST_REQ;
          end
        end
        ST_REQ: begin
          if (rd_status == 2'd0) begin
            rd_addr      <= addr_r;
            rd_burst_len <= 4'(beats_s - 5'd1);
            beats_r      <= beats_s;
            last_idx_r   <= last_idx_s;
            rd_enable    <= 1'b1;
            state_r      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rd_status[1]) begin
            rd_enable   <= 1'b0;
            buf_r       <= rd_data;
            addr_r      <= addr_r + (ADDR_WIDTH'(beats_r) << SIZE);
            remaining_r <= remaining_r - 16'(beats_r);
            // Status 3 abandons the rest of the job; the captured bytes are never shown.
            if (rd_status[0]) begin
              error   <= 1'b1;
              state_r <= ST_FINISH;
            end else begin
              byte_idx_r <= '0;
              out_data   <= rd_data[7:0];
              out_valid  <= 1'b1;
              state_r    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (byte_idx_r == last_idx_r) begin
              out_valid <= 1'b0;
              state_r   <= (remaining_r != 16'd0) ? ST_REQ : ST_FINISH;
            end else begin
              byte_idx_r <= next_idx_s;
              out_data   <= buf_shift_s[7:0];
            end
          end
        end
        ST_FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_byte_streamer.sv
// Self-checking bench for axi_rd_byte_streamer: axi_rd responder, byte collector,
// a table of directed jobs, hand-written latency/reset sequences and random jobs vs. a model.
module tb_axi_rd_byte_streamer;

  localparam int AW  = 32;
  localparam int BW  = 32;
  localparam int MB  = 4;
  localparam int BPB = BW / 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [15:0]       num_words;
  logic              busy, done, error, rd_enable;
  logic [7:0]        rd_id;
  logic [AW-1:0]     rd_addr;
  logic [3:0]        rd_burst_len;
  logic [2:0]        rd_burst_size;
  logic [MB*BW-1:0]  rd_data;
  logic [1:0]        rd_status;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  axi_rd_byte_streamer #(
    .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .MAX_BURST_LEN(MB), .RD_ID(8'd0)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .error(error),
    .rd_enable(rd_enable), .rd_id(rd_id), .rd_addr(rd_addr),
    .rd_burst_len(rd_burst_len), .rd_burst_size(rd_burst_size),
    .rd_data(rd_data), .rd_status(rd_status), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Job context written only by the main sequence.
  logic [31:0] job_base  = 32'd0;
  logic [7:0]  job_seed  = 8'd0;
  int          err_k     = -1;
  int          ready_mode = 0;
  int          lat_fixed = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory contents: byte at address a is its offset from the job base, xor a per-job seed.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] d;
    d = a - job_base;
    return d[7:0] ^ job_seed;
  endfunction

  // axi_rd responder: records each request, returns status 2 (or 3 on the chosen burst).
  logic [31:0] r_addr_q[$];
  logic [3:0]  r_len_q[$];
  int          resp_bad = 0;
  initial begin
    int rs = 0;
    int cnt = 0;
    int rk = 0;
    logic [31:0] a = 32'd0;
    logic [3:0]  l = 4'd0;
    rd_status = 2'd0;
    rd_data   = '0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        rs = 0; rk = 0; rd_status = 2'd0;
      end else begin
        if (!busy) rk = 0;
        case (rs)
          0: if (rd_enable) begin
            if (out_valid) resp_bad++;
            a = rd_addr; l = rd_burst_len;
            r_addr_q.push_back(a); r_len_q.push_back(l);
            cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
            rd_status = 2'd1; rs = 1;
          end
          1: begin
            if (!rd_enable || rd_addr !== a || rd_burst_len !== l) resp_bad++;
            if (cnt == 0) begin
              for (int k = 0; k < MB; k++)
                for (int j = 0; j < BPB; j++)
                  rd_data[(k*BPB+j)*8 +: 8] = (k <= int'(l)) ? mem_byte(a + 32'(k*BPB + j)) : 8'hEE;
              rd_status = (rk == err_k) ? 2'd3 : 2'd2;
              rs = 2;
            end else cnt--;
          end
          default: begin
            if (rd_enable) resp_bad++;
            if (rd_status == 2'd2 && !out_valid) resp_bad++;
            if (rd_status == 2'd3 && out_valid) resp_bad++;
            rd_status = 2'd0;
            rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            rk++; rs = 0;
          end
        endcase
      end
    end
  end

  // Byte collector: drives out_ready, records transferred bytes, watches stalled data.
  logic [7:0] got_q[$];
  int         stall_bad = 0;
  initial begin
    logic stalled = 1'b0;
    logic [7:0] sd = 8'd0;
    out_ready = 1'b1;
    forever begin
      @(negedge clock);
      if (reset) stalled = 1'b0;
      else begin
        if (stalled && (!out_valid || out_data !== sd)) stall_bad++;
        out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (out_valid && out_ready) got_q.push_back(out_data);
        stalled = out_valid && !out_ready;
        sd = out_data;
      end
    end
  end

  task automatic run_job(input logic [31:0] base, input int num, input int ek, input int mode,
                         input logic [7:0] seed, input bit inject,
                         output int n_req, output int n_bytes, output logic err_o);
    logic [31:0] ea[$];
    int          el[$];
    logic [7:0]  eb[$];
    logic [31:0] a;
    int rem, k, req0, got0, n;
    logic exp_err;
    job_base = base & 32'hFFFF_FFFC; job_seed = seed; err_k = ek; ready_mode = mode;
    // Reference model: split by remaining, burst limit and 4 KB page edge.
    a = job_base; rem = num; k = 0; exp_err = 1'b0;
    while (rem > 0) begin
      int page, beats;
      page  = (4096 - int'(a[11:0])) / BPB;
      beats = rem;
      if (beats > MB) beats = MB;
      if (beats > page) beats = page;
      ea.push_back(a); el.push_back(beats - 1);
      if (k == ek) begin exp_err = 1'b1; break; end
      for (int i = 0; i < beats*BPB; i++) eb.push_back(mem_byte(a + 32'(i)));
      a = a + 32'(beats*BPB); rem -= beats; k++;
    end
    req0 = r_addr_q.size(); got0 = got_q.size();
    @(posedge clock); #1;
    start = 1'b1; base_addr = base; num_words = 16'(num);
    @(posedge clock); #1;
    start = 1'b0; base_addr = $urandom(); num_words = 16'($urandom());
    chk("busy_after_start", busy, 1);
    chk("en_lat1", rd_enable, 0);
    @(posedge clock); #1;
    chk("en_lat2", rd_enable, (num != 0));
    chk("done_num0", done, (num == 0));
    if (inject) begin start = 1'b1; base_addr = 32'hDEAD_0000; num_words = 16'd7; end
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clock); #1; start = 1'b0; n++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("error", error, exp_err);
    chk("busy_end", busy, 0);
    n_req = r_addr_q.size() - req0;
    n_bytes = got_q.size() - got0;
    err_o = error;
    chk("req_count", n_req, ea.size());
    for (int i = 0; i < n_req && i < ea.size(); i++) begin
      chk("req_addr", r_addr_q[req0+i], ea[i]);
      chk("req_len", r_len_q[req0+i], el[i]);
    end
    chk("byte_count", n_bytes, eb.size());
    for (int i = 0; i < n_bytes && i < eb.size(); i++)
      chk("byte", got_q[got0+i], eb[i]);
    @(posedge clock); #1;
    chk("done_pulse", done, 0);
    chk("resp_protocol", resp_bad, 0);
    chk("stall_stable", stall_bad, 0);
  endtask

  typedef struct {
    logic [31:0] base;
    int          num;
    int          ek;
    int          mode;
    int          exp_req;
    int          exp_bytes;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int nr, nb, n;
    logic e;
    tbl[0] = '{32'h0000_1000,  4, -1, 0, 1, 16, 1'b0};
    tbl[1] = '{32'h0000_1000, 10, -1, 0, 3, 40, 1'b0};
    tbl[2] = '{32'h0000_1FF8,  4, -1, 0, 2, 16, 1'b0};
    tbl[3] = '{32'h0000_1000, 10,  1, 0, 2, 16, 1'b1};
    tbl[4] = '{32'h0000_1000,  0, -1, 0, 0,  0, 1'b0};
    tbl[5] = '{32'h0000_1FFB,  3, -1, 1, 2, 12, 1'b0};
    tbl[6] = '{32'h0000_2000,  9,  0, 1, 1,  0, 1'b1};
    tbl[7] = '{32'hFFFF_FFF8,  5, -1, 1, 2, 20, 1'b0};

    reset = 1'b1; start = 1'b0; base_addr = 32'd0; num_words = 16'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_rd_enable", rd_enable, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_burst_len", rd_burst_len, 0);
    chk("rd_burst_size", rd_burst_size, 3'd2);
    chk("rd_id", rd_id, 8'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_job(tbl[i].base, tbl[i].num, tbl[i].ek, tbl[i].mode, 8'd0, 1'b0, nr, nb, e);
      chk("tbl_req", nr, tbl[i].exp_req);
      chk("tbl_bytes", nb, tbl[i].exp_bytes);
      chk("tbl_err", e, tbl[i].exp_err);
    end
    chk("first_byte", got_q[0], 8'h00);
    chk("sixteenth_byte", got_q[15], 8'h0F);

    // start pulsed while busy must not disturb the running job
    run_job(32'h0000_3000, 6, -1, 0, 8'h5A, 1'b1, nr, nb, e);
    chk("inject_bytes", nb, 24);

    // Reset asserted while a burst is outstanding
    lat_fixed = 6;
    @(posedge clock); #1;
    start = 1'b1; base_addr = 32'h0000_5000; num_words = 16'd4;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (!rd_enable && n < 20) begin @(posedge clock); #1; n++; end
    chk("wait_en_seen", rd_enable, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rstwait_rd_enable", rd_enable, 0);
    chk("rstwait_out_valid", out_valid, 0);
    chk("rstwait_busy", busy, 0);
    reset = 1'b0;
    lat_fixed = -1;
    @(posedge clock); #1;
    chk("rstwait_idle", busy, 0);
    run_job(32'h0000_1000, 4, -1, 0, 8'h00, 1'b0, nr, nb, e);
    chk("after_rst_bytes", nb, 16);

    for (int i = 0; i < 25; i++) begin
      logic [31:0] b;
      int num, ek;
      b = $urandom();
      if (i % 5 == 4) b = 32'hFFFF_FF00 | 32'($urandom_range(200, 255));
      else b[11:0] = 12'hFFF - 12'($urandom_range(0, 40));
      num = $urandom_range(0, 20);
      ek  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_job(b, num, ek, 1, 8'($urandom()), (num > 0) && $urandom_range(0, 1) == 1, nr, nb, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
